// File: rtl/fifo_seq_ctrl.sv
// fifo_seq_ctrl
//   Sequencer for the bank of DIM delay-line FIFOs feeding the systolic array.
//   A job loads DIM host rows (valid/ready) into every FIFO lane. It then
//   drains the lanes with zeros for 2*DIM-1 enabled cycles while the array
//   computes. Finally it pulses done for one cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             job start pulse, honoured only when idle
//   abort             synchronous abort, highest priority, returns to idle
//   in_valid/in_ready host row handshake (in_ready high only while loading)
//   in_data           host row, lane i = in_data[i*BITS +: BITS]
//   stall             downstream backpressure, freezes the drain phase
//   fifo_en, fifo_d   registered per-lane shift enable / data to the FIFOs
//   array_en          registered systolic array compute enable
//   busy              high while loading or draining
//   done              one-cycle completion pulse
//   row_cnt           rows accepted in the current job
module fifo_seq_ctrl #(
    parameter  int DIM  = 8,
    parameter  int BITS = 8,
    localparam int CW   = $clog2(2*DIM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIM*BITS-1:0] in_data,
    input  logic                stall,
    output logic [DIM-1:0]      fifo_en,
    output logic [DIM*BITS-1:0] fifo_d,
    output logic                array_en,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       row_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_ROW   = CW'(DIM - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(2*DIM - 2);

    state_t        state;
    logic [CW-1:0] stream_cnt;

    // Decoded straight from state so in_ready drops in the same cycle the
    // controller leaves LOAD; no row can be accepted and then lost.
    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fifo_en    <= '0;
            fifo_d     <= '0;
            array_en   <= 1'b0;
            done       <= 1'b0;
            row_cnt    <= '0;
            stream_cnt <= '0;
        end else if (abort) begin
            // FIFO contents and row_cnt are deliberately left as they are.
            state    <= IDLE;
            fifo_en  <= '0;
            array_en <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fifo_en  <= '0;
                    array_en <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        state   <= LOAD;
                        row_cnt <= '0;
                    end
                end
                LOAD: begin
                    array_en <= 1'b0;
                    done     <= 1'b0;
                    if (in_valid) begin
                        fifo_en <= '1;
                        fifo_d  <= in_data;
                        row_cnt <= row_cnt + 1'b1;
                        if (row_cnt == LAST_ROW) begin
                            state      <= STREAM;
                            stream_cnt <= '0;
                        end
                    end else begin
                        fifo_en <= '0;
                    end
                end
                STREAM: begin
                    done <= 1'b0;
                    if (!stall) begin
                        fifo_en    <= '1;
                        fifo_d     <= '0;
                        array_en   <= 1'b1;
                        stream_cnt <= stream_cnt + 1'b1;
                        // Done is raised on the same edge that issues the
                        // final drain enable, so it coincides with busy falling.
                        if (stream_cnt == LAST_DRAIN) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        fifo_en  <= '0;
                        array_en <= 1'b0;
                    end
                end
                DONE: begin
                    fifo_en  <= '0;
                    array_en <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    fifo_en  <= '0;
                    array_en <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_seq_ctrl.md
Name: fifo_seq_ctrl

Overview:
Sequencer for the bank of DIM delay-line FIFOs that feed the systolic array. Accepts DIM input rows from the MMIO/host side over a valid/ready handshake and pushes each row into all FIFO lanes. It then flushes the lanes with zeros while enabling the array for a fixed drain window. Reports busy/done to the host, and supports downstream stall and synchronous abort.

Parameters:
DIM, 8, number of FIFO lanes, rows per job, and FIFO depth
BITS, 8, data width per lane
CW, $clog2(2*DIM), internal counter width (derived; not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  job start pulse; honoured only in IDLE
abort  input  1  synchronous abort; returns to IDLE from any state
in_valid  input  1  host row valid
in_ready  output  1  controller accepts row (high only in LOAD)
in_data  input  DIM*BITS  row; lane i = in_data[i*BITS +: BITS]
stall  input  1  downstream backpressure; freezes STREAM
fifo_en  output  DIM  per-lane shift enable to delay FIFOs (registered)
fifo_d  output  DIM*BITS  per-lane data to delay FIFOs (registered)
array_en  output  1  systolic array compute enable (registered)
busy  output  1  high in LOAD and STREAM
done  output  1  one-cycle pulse at job completion
row_cnt  output  CW  rows accepted in current job

Behaviour:
- Reset: state=IDLE; fifo_en=0, fifo_d=0, array_en=0, done=0, busy=0, in_ready=0, row_cnt=0, stream counter=0.
- States: IDLE, LOAD, STREAM, DONE. 2-bit encoding; no other reachable states. An illegal encoding recovers to IDLE.
- IDLE: on start=1 -> LOAD, row_cnt<=0. Outputs stay idle.
- LOAD: in_ready=1 (combinational from state). Handshake = in_valid & in_ready.
  - On a handshake: next cycle fifo_en={DIM{1}}, fifo_d=in_data; row_cnt++.
  - Without a handshake: next cycle fifo_en=0, and fifo_d holds its last value.
  - When the DIM-th row is accepted (row_cnt==DIM-1 at handshake) -> STREAM, stream counter<=0.
- STREAM: each non-stalled cycle, next cycle fifo_en=all 1, fifo_d=0, array_en=1, and the counter increments.
  - When stall=1: next cycle fifo_en=0, array_en=0, counter holds.
  - After exactly 2*DIM-1 non-stalled cycles (counter==2*DIM-2 with stall=0) -> DONE.
- DONE: done=1 for exactly one cycle; fifo_en=0, array_en=0; -> IDLE.
- busy=1 in LOAD and STREAM only. Combinational from state.
- Latency: row accepted at edge N produces fifo_en/fifo_d at cycle N+1. The first STREAM enable appears the cycle after the LOAD->STREAM transition.
- Priority: abort > everything.
  - abort=1 forces IDLE next cycle and zeroes fifo_en and array_en next cycle.
  - No done pulse. row_cnt is retained until the next start.
  - FIFO contents are not cleared; the host is responsible for re-flushing.
- start outside IDLE is ignored; start and abort in the same cycle means abort wins and the state stays IDLE.
- in_valid outside LOAD is ignored (in_ready=0). No rows are dropped during the LOAD->STREAM transition because in_ready falls with the state.
- Counters saturate by construction: row_cnt max DIM, stream counter max 2*DIM-2. No wrap is possible within a job.
- Reset asserted mid-job returns immediately to the reset values above.

Test Plan:
- DIM=4, BITS=8: start, then 4 back-to-back rows 0x04030201..0x10 0F0E0D -> fifo_en=4'hF on 4 consecutive cycles with matching fifo_d. Then 7 STREAM cycles with fifo_d=0 and array_en=1. Then done pulses once; busy falls the same cycle.
- LOAD with in_valid gaps (rows at cycles 0, 3, 4, 9) -> fifo_en high only the cycle after each handshake; row_cnt steps 1, 2, 3, 4; STREAM starts after the 4th row.
- STREAM with stall high for 3 cycles mid-drain -> fifo_en=0 and array_en=0 for those 3 cycles. Total enabled STREAM cycles is still 7; done is delayed by 3 cycles.
- abort during LOAD after 2 rows, and separately during STREAM -> IDLE next cycle, fifo_en=0, no done. A subsequent start runs a full clean job with row_cnt restarting at 0.
- start pulsed during LOAD/STREAM, and start+abort together in IDLE -> no state change, no extra done.
- rst_n asserted asynchronously mid-STREAM -> all outputs 0 immediately. After release the controller stays in IDLE until start.
